// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode encodings and reverse-shifter FSM states
package shifter_pkg;

  localparam logic [1:0] MODE_SLL     = 2'b00;
  localparam logic [1:0] MODE_SRA     = 2'b01;
  localparam logic [1:0] MODE_ROR     = 2'b10;
  localparam logic [1:0] MODE_SRL     = 2'b00;
  localparam logic [1:0] MODE_ROL     = 2'b01;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } rsh_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit logical-right / rotate-left step
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] next_data,
  output logic             bit_out
);

  // Both ROL encodings (01, 10) rotate; illegal never reaches the step.
  always_comb begin
    next_data = data;
    bit_out   = 1'b0;
    if (op == MODE_SRL) begin
      next_data = {1'b0, data[WIDTH-1:1]};
      bit_out   = data[0];
    end else begin
      next_data = {data[WIDTH-2:0], data[WIDTH-1]};
      bit_out   = data[WIDTH-1];
    end
  end

endmodule

// File: rtl/seq_rev_shifter.sv
// rtl/seq_rev_shifter.sv - multi-cycle SRL/ROL shifter behind valid/ready handshakes
module seq_rev_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [WIDTH-1:0]           Shift_In,
  input  logic [$clog2(WIDTH)-1:0]   Shift_Val,
  input  logic [1:0]                 Mode,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [WIDTH-1:0]           Shift_Out,
  output logic                       Carry_Out,
  output logic                       Zero,
  output logic                       Err
);

  localparam int CW = $clog2(WIDTH);

  rsh_state_t        state_q, state_d;
  logic [WIDTH-1:0]  data_q;
  logic [CW-1:0]     count_q;
  logic [1:0]        op_q;
  logic              carry_q;
  logic              err_q;
  logic [WIDTH-1:0]  step_data;
  logic              step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data      (data_q),
    .op        (op_q),
    .next_data (step_data),
    .bit_out   (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (In_Valid) begin
        if (Shift_Val != '0 && Mode != MODE_ILLEGAL) state_d = SHIFT;
        else                                         state_d = DONE;
      end
      SHIFT: if (count_q == CW'(1)) state_d = DONE;
      DONE:  if (Out_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    In_Ready  = (state_q == IDLE);
    Out_Valid = (state_q == DONE);
  end

  // Operand, count and flags are only touched on accept and while shifting,
  // so DONE holds the result stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      op_q    <= MODE_SRL;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (In_Valid) begin
          data_q  <= Shift_In;
          count_q <= Shift_Val;
          op_q    <= Mode;
          carry_q <= 1'b0;
          err_q   <= (Mode == MODE_ILLEGAL);
        end
        SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_bit;
          count_q <= count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign Shift_Out = data_q;
  assign Carry_Out = carry_q;
  assign Err       = err_q;
  assign Zero      = ~|data_q;

endmodule

// File: tb/tb_seq_rev_shifter.sv
// tb/tb_seq_rev_shifter.sv - scoreboard bench for seq_rev_shifter
module tb_seq_rev_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [15:0] Shift_In = '0;
  logic [3:0]  Shift_Val = '0;
  logic [1:0]  Mode = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [15:0] Shift_Out;
  logic        Carry_Out;
  logic        Zero;
  logic        Err;

  seq_rev_shifter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Shift_Out (Shift_Out),
    .Carry_Out (Carry_Out),
    .Zero      (Zero),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: checks first-valid latency, then compares result on handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (Out_Valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(Out_Valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          seen = 1;
        end
        if (Out_Ready) begin
          check("shift_out", 32'(Shift_Out), 32'(exp_q[0].d));
          check("carry_out", 32'(Carry_Out), 32'(exp_q[0].c));
          check("zero",      32'(Zero),      32'(exp_q[0].z));
          check("err",       32'(Err),       32'(exp_q[0].e));
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] d, input logic [3:0] n, input logic [1:0] m,
                       input logic [15:0] ed, input logic ec, input logic ee, input bit push);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (!In_Ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!In_Ready) check("in_ready_timeout", 32'(In_Ready), 32'd1);
    Shift_In  = d;
    Shift_Val = n;
    Mode      = m;
    In_Valid  = 1'b1;
    if (push) begin
      e.d = ed; e.c = ec; e.z = (ed == 16'h0); e.e = ee;
      e.lat = (n == 0 || m == 2'b11) ? 1 : int'(n) + 1;
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic drain;
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_in_ready",  32'(In_Ready),  32'd1);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_shift_out", 32'(Shift_Out), 32'd0);
    check("rst_carry",     32'(Carry_Out), 32'd0);
    check("rst_err",       32'(Err),       32'd0);
    check("rst_zero",      32'(Zero),      32'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h8001, 4'd4,  2'b00, 16'h0800, 1'b0, 1'b0, 1);
    issue(16'h8001, 4'd1,  2'b01, 16'h0003, 1'b1, 1'b0, 1);
    issue(16'h8001, 4'd15, 2'b10, 16'hC000, 1'b0, 1'b0, 1);
    issue(16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0, 1'b0, 1);
    issue(16'h1234, 4'd5,  2'b11, 16'h1234, 1'b0, 1'b1, 1);
    issue(16'h0001, 4'd1,  2'b00, 16'h0000, 1'b1, 1'b0, 1);
    drain();

    // Backpressure: hold Out_Ready low in DONE while a new request knocks.
    Out_Ready = 1'b0;
    issue(16'hA5A5, 4'd3, 2'b00, 16'h14B4, 1'b1, 1'b0, 1);
    for (int w = 0; w < 50 && !Out_Valid; w++) @(negedge clk);
    check("bp_reached_done", 32'(Out_Valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      Shift_In = 16'hFFFF; Shift_Val = 4'd1; Mode = 2'b00; In_Valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready",  32'(In_Ready),  32'd0);
      check("bp_out_valid", 32'(Out_Valid), 32'd1);
      check("bp_shift_out", 32'(Shift_Out), 32'h14B4);
      check("bp_carry",     32'(Carry_Out), 32'd1);
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_back_idle", 32'(In_Ready), 32'd1);

    // Reset two cycles into a 10-step shift.
    issue(16'hF0F0, 4'd10, 2'b01, 16'h0, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(In_Ready),  32'd1);
    check("mid_rst_out_valid", 32'(Out_Valid), 32'd0);
    check("mid_rst_shift_out", 32'(Shift_Out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (Out_Valid) check("stale_out_valid", 32'(Out_Valid), 32'd0);
    end
    check("post_rst_idle", 32'(In_Ready), 32'd1);

    issue(16'h00F0, 4'd2, 2'b00, 16'h003C, 1'b0, 1'b0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_rev_shifter.md
# seq_rev_shifter

Multi-cycle, one-bit-per-cycle shifter for the 16-bit datapath that performs the opposite-direction operations to the single-cycle barrel shifter: logical right shift (SRL) and rotate left (ROL). It sits beside the ALU behind a valid/ready handshake and serves long-latency or low-area shift requests. It also reports the last bit shifted out and a zero flag.

## Interface
Parameters:
- WIDTH, 16, datapath width; the shift amount is $clog2(WIDTH) bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- In_Valid  in  1  request present.
- In_Ready  out  1  block can accept a request; high only in IDLE.
- Shift_In  in  WIDTH  operand.
- Shift_Val  in  4  shift amount, 0–15.
- Mode  in  2  operation: 00 = SRL, 01 = ROL, 10 = ROL, 11 = illegal.
- Out_Valid  out  1  result available; high only in DONE.
- Out_Ready  in  1  consumer takes the result.
- Shift_Out  out  WIDTH  result.
- Carry_Out  out  1  last bit shifted out or wrapped; 0 if the amount is 0.
- Zero  out  1  Shift_Out == 0.
- Err  out  1  the request used Mode 11.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - In_Ready = 1.
  - On In_Valid && In_Ready (accept edge E0), capture Shift_In into the data register, Shift_Val into the count, and Mode into the op register.
  - Go to SHIFT if the count != 0 and Mode != 11; otherwise go to DONE.
- **SHIFT**, on each edge:
  - SRL: data = {0, data[15:1]}, Carry_Out = data[0].
  - ROL: data = {data[14:0], data[15]}, Carry_Out = data[15].
  - Decrement the count. When the count transitions 1 to 0, go to DONE.
- **DONE**
  - Out_Valid = 1. Shift_Out, Carry_Out, Zero and Err stay stable until Out_Valid && Out_Ready.
  - The handshake edge returns the block to IDLE.
- **Mode 11**: result = Shift_In unchanged, Carry_Out = 0, Err = 1, no shift cycles.
- **Amount 0**: result = Shift_In, Carry_Out = 0, Err = 0.
- **During SHIFT and DONE**: In_Ready = 0. In_Valid is ignored and the input buses are not sampled.
- **Zero**: combinational from the data register; meaningful only while Out_Valid is high.
- **Err and Carry_Out**: cleared on each accept.

## Timing
- Reset values: In_Ready = 1 (IDLE), Out_Valid = 0, Shift_Out = 0, Carry_Out = 0, Err = 0, Zero = 1. The FSM enters IDLE and the count is 0.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. The result is discarded and no Out_Valid is produced.
- Latency, amount N from 1 to 15: shifts occur on edges E1..EN. Out_Valid is high in the cycle after EN, i.e. N+1 edges after E0.
- Latency, amount 0 or Mode 11: Out_Valid is high in the cycle after E0.
- Out_Valid and Out_Ready high on the same edge: return to IDLE, In_Ready = 1 in the next cycle. There is no same-cycle accept of a new request in DONE (no bypass).
- Throughput: at most one request per N+2 cycles with Out_Ready held high.
- All outputs are registered, except In_Ready and Out_Valid (state decode) and Zero (a reduction of the data register).

## Structure
- Shared package `shifter_pkg`:
  - mode constants MODE_SLL = 2'b00, MODE_SRA = 2'b01, MODE_ROR = 2'b10, MODE_SRL = 2'b00, MODE_ROL = 2'b01, MODE_ILLEGAL = 2'b11;
  - the FSM state enum `rsh_state_t` (IDLE, SHIFT, DONE).
- One sub-module, `shift_step`: combinational single-bit SRL/ROL with inputs data and op, and outputs next data and bit-out. It is instantiated once in the SHIFT datapath.
- Top level: FSM, 4-bit down-counter, data/op/flag registers.

## Test plan
- SRL: Shift_In 0x8001, Shift_Val 4, Mode 00 -> Shift_Out 0x0800, Carry_Out 0, Zero 0; Out_Valid exactly 5 edges after accept.
- ROL wrap: 0x8001, amount 1, Mode 01 -> 0x0003, Carry_Out 1. Same operand with amount 15, Mode 10 -> 0xC000, Carry_Out 0.
- Amount 0 and illegal mode:
  - 0x1234, amount 0 -> 0x1234, Carry_Out 0, Err 0, Out_Valid one edge after accept.
  - Mode 11 -> 0x1234, Err 1.
- SRL to zero: 0x0001, amount 1, Mode 00 -> 0x0000, Zero 1, Carry_Out 1.
- Backpressure: Out_Ready held low for 3 cycles in DONE -> outputs stable and In_Ready 0. A new In_Valid with 0xFFFF is ignored; the original result is delivered, then IDLE.
- Reset mid-SHIFT: assert rst two cycles into a 10-cycle shift -> immediately In_Ready 1, Out_Valid 0, Shift_Out 0. No stale Out_Valid after release.
